// File: rtl/ck_gate_ctrl_pkg.sv
// Shared definitions for the clock-gating controller: FSM encodings,
// the default gated-cycle counter width and the idle-qualification helper.
package ck_gate_ctrl_pkg;

    // Main gating FSM state type and its encodings
    typedef logic [1:0] ckg_state_t;

    localparam ckg_state_t CKG_RUN   = 2'd0;
    localparam ckg_state_t CKG_COUNT = 2'd1;
    localparam ckg_state_t CKG_GATED = 2'd2;

    // Default width of the gated-cycle profiling counter
    localparam int CKG_CNT_W = 32;

    // The core may have its main clock stopped only when it is halted or
    // sleeping and nothing else needs it. Any one wake source (load
    // outstanding, bus traffic, host access, interrupt) or production test
    // mode keeps the clock running.
    function automatic logic ckg_idle(
        input logic halt_r,
        input logic sleep_r,
        input logic ld_pending,
        input logic mem_busy,
        input logic host_access,
        input logic irq_req,
        input logic test_mode
    );
        logic quiet_s;
        quiet_s = ~ld_pending & ~mem_busy & ~host_access & ~irq_req & ~test_mode;
        return (halt_r | sleep_r) & quiet_s;
    endfunction

endpackage

// File: rtl/ck_hyst_cnt.sv
// Hysteresis counter: counts consecutive cycles in which 'cond' is high,
// saturating at HYST. 'reached' is high in a cycle where cond is high and
// at least HYST earlier consecutive cycles also had cond high, so the
// consumer acts on the edge that samples the (HYST+1)-th consecutive
// qualifying cycle. With HYST=0 'reached' simply follows cond.
// Any cycle with cond low clears the count on the next edge.
module ck_hyst_cnt #(
    parameter int HYST = 4
) (
    input  logic clk_ungated,
    input  logic rst,
    input  logic cond,
    output logic reached
);

    // Counter only needs to represent 0..HYST; keep at least one bit
    localparam int CW = (HYST < 1) ? 1 : $clog2(HYST + 1);
    localparam logic [CW-1:0] HYST_C = CW'(HYST);
    localparam logic [CW-1:0] ONE_C  = CW'(1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Next count: restart on a non-qualifying cycle, otherwise climb to HYST and hold
    always_comb begin
        cnt_d = cnt_q;
        if (!cond) begin
            cnt_d = '0;
        end else if (cnt_q != HYST_C) begin
            cnt_d = cnt_q + ONE_C;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register with synchronous reset
    always_ff @(posedge clk_ungated) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign reached = cond & (cnt_q == HYST_C);

endmodule

// File: rtl/ck_gate_ctrl.sv
// Clock-gating controller running on the never-gated core clock.
// Decides when the main and DMP clocks may stop and drives registered,
// glitch-free disable levels to the downstream enable latches. Idle must
// persist for IDLE_HYST cycles before the main clock gates; any wake
// source reopens the clock after a single edge. Gated cycles are counted
// in a saturating profiling counter.
module ck_gate_ctrl
    import ck_gate_ctrl_pkg::*;
#(
    parameter int IDLE_HYST = 4,
    parameter int DMP_HYST  = 2,
    parameter int CNT_W     = CKG_CNT_W
) (
    input  logic             clk_ungated,
    input  logic             rst,
    input  logic             halt_r,
    input  logic             sleep_r,
    input  logic             ld_pending,
    input  logic             mem_busy,
    input  logic             host_access,
    input  logic             irq_req,
    input  logic             dmp_idle,
    input  logic             test_mode,
    input  logic             gcnt_clr,
    output logic             ck_disable,
    output logic             ck_dmp_gated,
    output logic [CNT_W-1:0] gated_cycles
);

    localparam logic [CNT_W-1:0] GCNT_ONE = CNT_W'(1);

    logic             idle_s;
    logic             dmp_cond_s;
    logic             main_reached_s;
    logic             dmp_reached_s;

    ckg_state_t       state_q;
    ckg_state_t       state_d;
    logic             ck_disable_q;
    logic             ck_disable_d;
    logic             ck_dmp_gated_q;
    logic             ck_dmp_gated_d;
    logic [CNT_W-1:0] gcnt_q;
    logic [CNT_W-1:0] gcnt_d;

    // Test mode is folded into both qualifiers, so asserting it clears the
    // hysteresis counters and drops both gates on the following edge.
    assign idle_s     = ckg_idle(halt_r, sleep_r, ld_pending, mem_busy,
                                 host_access, irq_req, test_mode);
    assign dmp_cond_s = dmp_idle & ~test_mode;

    // Main-path idle hysteresis; its count stands in for the COUNT-state down-counter
    ck_hyst_cnt #(
        .HYST (IDLE_HYST)
    ) u_main_hyst (
        .clk_ungated (clk_ungated),
        .rst         (rst),
        .cond        (idle_s),
        .reached     (main_reached_s)
    );

    // DMP-path hysteresis, independent of the main FSM
    ck_hyst_cnt #(
        .HYST (DMP_HYST)
    ) u_dmp_hyst (
        .clk_ungated (clk_ungated),
        .rst         (rst),
        .cond        (dmp_cond_s),
        .reached     (dmp_reached_s)
    );

    // Main FSM next state; a wake in the same cycle the count expires wins
    always_comb begin
        state_d = state_q;
        case (state_q)
            CKG_RUN: begin
                if (main_reached_s) begin
                    state_d = CKG_GATED;
                end else if (idle_s) begin
                    state_d = CKG_COUNT;
                end else begin
                    state_d = CKG_RUN;
                end
            end
            CKG_COUNT: begin
                if (!idle_s) begin
                    state_d = CKG_RUN;
                end else if (main_reached_s) begin
                    state_d = CKG_GATED;
                end else begin
                    state_d = CKG_COUNT;
                end
            end
            CKG_GATED: begin
                if (!idle_s) begin
                    state_d = CKG_RUN;
                end else begin
                    state_d = CKG_GATED;
                end
            end
            default: begin
                state_d = CKG_RUN;
            end
        endcase
    end

    // Output levels are decided from next state so wake takes exactly one edge
    always_comb begin
        ck_disable_d   = (state_d == CKG_GATED);
        ck_dmp_gated_d = dmp_reached_s;
    end

    // Saturating gated-cycle counter; clear beats increment
    always_comb begin
        gcnt_d = gcnt_q;
        if (gcnt_clr) begin
            gcnt_d = '0;
        end else if (ck_disable_q && (gcnt_q != {CNT_W{1'b1}})) begin
            gcnt_d = gcnt_q + GCNT_ONE;
        end else begin
            gcnt_d = gcnt_q;
        end
    end

    // FSM state register
    always_ff @(posedge clk_ungated) begin
        if (rst) begin
            state_q <= CKG_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Gate-level output flops feeding the downstream enable latches
    always_ff @(posedge clk_ungated) begin
        if (rst) begin
            ck_disable_q   <= 1'b0;
            ck_dmp_gated_q <= 1'b0;
        end else begin
            ck_disable_q   <= ck_disable_d;
            ck_dmp_gated_q <= ck_dmp_gated_d;
        end
    end

    // Gated-cycle profiling counter register
    always_ff @(posedge clk_ungated) begin
        if (rst) begin
            gcnt_q <= '0;
        end else begin
            gcnt_q <= gcnt_d;
        end
    end

    assign ck_disable   = ck_disable_q;
    assign ck_dmp_gated = ck_dmp_gated_q;
    assign gated_cycles = gcnt_q;

endmodule

// File: tb/tb_ck_gate_ctrl.sv
// Directed testbench for ck_gate_ctrl. Main DUT: IDLE_HYST=4, DMP_HYST=2,
// CNT_W=4 (so saturation is reachable). Second DUT: zero hysteresis.
module tb_ck_gate_ctrl;

    logic       clk_ungated;
    logic       rst;
    logic       halt_r;
    logic       sleep_r;
    logic       ld_pending;
    logic       mem_busy;
    logic       host_access;
    logic       irq_req;
    logic       dmp_idle;
    logic       test_mode;
    logic       gcnt_clr;

    logic       ck_disable;
    logic       ck_dmp_gated;
    logic [3:0] gated_cycles;
    logic       z_ck_disable;
    logic       z_ck_dmp_gated;
    logic [7:0] z_gated_cycles;

    int checks;
    int failures;

    ck_gate_ctrl #(.IDLE_HYST(4), .DMP_HYST(2), .CNT_W(4)) u_dut (
        .clk_ungated (clk_ungated), .rst (rst), .halt_r (halt_r), .sleep_r (sleep_r),
        .ld_pending (ld_pending), .mem_busy (mem_busy), .host_access (host_access),
        .irq_req (irq_req), .dmp_idle (dmp_idle), .test_mode (test_mode),
        .gcnt_clr (gcnt_clr), .ck_disable (ck_disable), .ck_dmp_gated (ck_dmp_gated),
        .gated_cycles (gated_cycles)
    );

    ck_gate_ctrl #(.IDLE_HYST(0), .DMP_HYST(0), .CNT_W(8)) u_dut_z (
        .clk_ungated (clk_ungated), .rst (rst), .halt_r (halt_r), .sleep_r (sleep_r),
        .ld_pending (ld_pending), .mem_busy (mem_busy), .host_access (host_access),
        .irq_req (irq_req), .dmp_idle (dmp_idle), .test_mode (test_mode),
        .gcnt_clr (gcnt_clr), .ck_disable (z_ck_disable), .ck_dmp_gated (z_ck_dmp_gated),
        .gated_cycles (z_gated_cycles)
    );

    initial begin
        clk_ungated = 1'b0;
        forever #5 clk_ungated = ~clk_ungated;
    end

    // Advance past the next rising edge; inputs change and outputs are sampled here
    task automatic tick();
        @(posedge clk_ungated);
        #1;
    endtask

    task automatic clear_inputs();
        halt_r = 1'b0; sleep_r = 1'b0; ld_pending = 1'b0; mem_busy = 1'b0;
        host_access = 1'b0; irq_req = 1'b0; dmp_idle = 1'b0; test_mode = 1'b0;
        gcnt_clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL reset_ck_disable got=%0b exp=0", ck_disable); end
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL reset_ck_dmp_gated got=%0b exp=0", ck_dmp_gated); end
        checks++; if (gated_cycles !== 4'd0) begin failures++; $display("FAIL reset_gated_cycles got=%0d exp=0", gated_cycles); end
        checks++; if (z_ck_disable !== 1'b0) begin failures++; $display("FAIL reset_z_ck_disable got=%0b exp=0", z_ck_disable); end
        rst = 1'b0;
    endtask

    task automatic test_gate_latency();
        halt_r = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL gate_early edge=%0d got=%0b exp=0", i, ck_disable); end
        end
        tick();
        checks++; if (ck_disable !== 1'b1) begin failures++; $display("FAIL gate_edge got=%0b exp=1", ck_disable); end
        checks++; if (gated_cycles !== 4'd0) begin failures++; $display("FAIL gate_cnt_start got=%0d exp=0", gated_cycles); end
        repeat (10) tick();
        checks++; if (gated_cycles !== 4'd10) begin failures++; $display("FAIL gate_cnt10 got=%0d exp=10", gated_cycles); end
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL gate_dmp_quiet got=%0b exp=0", ck_dmp_gated); end
    endtask

    task automatic test_reset_mid_gated();
        dmp_idle = 1'b1;
        repeat (3) tick();
        checks++; if (ck_dmp_gated !== 1'b1) begin failures++; $display("FAIL rstg_pre_dmp got=%0b exp=1", ck_dmp_gated); end
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL rstg_dis cyc=%0d got=%0b exp=0", i, ck_disable); end
            checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL rstg_dmp cyc=%0d got=%0b exp=0", i, ck_dmp_gated); end
            checks++; if (gated_cycles !== 4'd0) begin failures++; $display("FAIL rstg_cnt cyc=%0d got=%0d exp=0", i, gated_cycles); end
        end
        rst = 1'b0;
        repeat (4) tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL rstg_regate_early got=%0b exp=0", ck_disable); end
        tick();
        checks++; if (ck_disable !== 1'b1) begin failures++; $display("FAIL rstg_regate got=%0b exp=1", ck_disable); end
        halt_r = 1'b0;
        dmp_idle = 1'b0;
        tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL rstg_wake got=%0b exp=0", ck_disable); end
    endtask

    task automatic test_wake_priority();
        halt_r = 1'b1;
        repeat (4) tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL wp_count got=%0b exp=0", ck_disable); end
        irq_req = 1'b1;
        tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL wp_cnt0_irq got=%0b exp=0", ck_disable); end
        irq_req = 1'b0;
        repeat (4) tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL wp_restart got=%0b exp=0", ck_disable); end
        tick();
        checks++; if (ck_disable !== 1'b1) begin failures++; $display("FAIL wp_regate got=%0b exp=1", ck_disable); end
        irq_req = 1'b1;
        tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL wp_gated_irq got=%0b exp=0", ck_disable); end
        irq_req = 1'b0;
        halt_r = 1'b0;
        tick();
        // Each remaining wake source against a sleeping core
        for (int s = 0; s < 4; s++) begin
            sleep_r = 1'b1;
            repeat (5) tick();
            checks++; if (ck_disable !== 1'b1) begin failures++; $display("FAIL src_gate src=%0d got=%0b exp=1", s, ck_disable); end
            ld_pending  = (s == 0);
            mem_busy    = (s == 1);
            host_access = (s == 2);
            irq_req     = (s == 3);
            tick();
            checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL src_wake src=%0d got=%0b exp=0", s, ck_disable); end
            clear_inputs();
            tick();
        end
    endtask

    task automatic test_dmp();
        dmp_idle = 1'b1;
        tick();
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL dmp_e1 got=%0b exp=0", ck_dmp_gated); end
        tick();
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL dmp_e2 got=%0b exp=0", ck_dmp_gated); end
        tick();
        checks++; if (ck_dmp_gated !== 1'b1) begin failures++; $display("FAIL dmp_gate got=%0b exp=1", ck_dmp_gated); end
        dmp_idle = 1'b0;
        tick();
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL dmp_wake got=%0b exp=0", ck_dmp_gated); end
        dmp_idle = 1'b1;
        tick();
        tick();
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL dmp_restart got=%0b exp=0", ck_dmp_gated); end
        tick();
        checks++; if (ck_dmp_gated !== 1'b1) begin failures++; $display("FAIL dmp_regate got=%0b exp=1", ck_dmp_gated); end
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL dmp_main_indep got=%0b exp=0", ck_disable); end
        dmp_idle = 1'b0;
        tick();
    endtask

    task automatic test_test_mode();
        halt_r = 1'b1;
        dmp_idle = 1'b1;
        repeat (5) tick();
        checks++; if (ck_disable !== 1'b1) begin failures++; $display("FAIL tm_pre_dis got=%0b exp=1", ck_disable); end
        checks++; if (ck_dmp_gated !== 1'b1) begin failures++; $display("FAIL tm_pre_dmp got=%0b exp=1", ck_dmp_gated); end
        test_mode = 1'b1;
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL tm_dis cyc=%0d got=%0b exp=0", i, ck_disable); end
            checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL tm_dmp cyc=%0d got=%0b exp=0", i, ck_dmp_gated); end
        end
        test_mode = 1'b0;
        tick();
        tick();
        checks++; if (ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL tm_rel_dmp_early got=%0b exp=0", ck_dmp_gated); end
        tick();
        checks++; if (ck_dmp_gated !== 1'b1) begin failures++; $display("FAIL tm_rel_dmp got=%0b exp=1", ck_dmp_gated); end
        tick();
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL tm_rel_dis_early got=%0b exp=0", ck_disable); end
        tick();
        checks++; if (ck_disable !== 1'b1) begin failures++; $display("FAIL tm_rel_dis got=%0b exp=1", ck_disable); end
    endtask

    task automatic test_saturation();
        gcnt_clr = 1'b1;
        tick();
        checks++; if (gated_cycles !== 4'd0) begin failures++; $display("FAIL sat_clr got=%0d exp=0", gated_cycles); end
        gcnt_clr = 1'b0;
        tick();
        checks++; if (gated_cycles !== 4'd1) begin failures++; $display("FAIL sat_first got=%0d exp=1", gated_cycles); end
        repeat (20) tick();
        checks++; if (gated_cycles !== 4'd15) begin failures++; $display("FAIL sat_top got=%0d exp=15", gated_cycles); end
        tick();
        checks++; if (gated_cycles !== 4'd15) begin failures++; $display("FAIL sat_nowrap got=%0d exp=15", gated_cycles); end
        gcnt_clr = 1'b1;
        tick();
        checks++; if (gated_cycles !== 4'd0) begin failures++; $display("FAIL sat_clr2 got=%0d exp=0", gated_cycles); end
        gcnt_clr = 1'b0;
        tick();
        checks++; if (gated_cycles !== 4'd1) begin failures++; $display("FAIL sat_resume got=%0d exp=1", gated_cycles); end
        halt_r = 1'b0;
        tick();
        tick();
        checks++; if (gated_cycles !== 4'd2) begin failures++; $display("FAIL sat_hold got=%0d exp=2", gated_cycles); end
    endtask

    task automatic test_zero_hyst();
        clear_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        halt_r = 1'b1;
        tick();
        checks++; if (z_ck_disable !== 1'b1) begin failures++; $display("FAIL z_gate got=%0b exp=1", z_ck_disable); end
        checks++; if (ck_disable !== 1'b0) begin failures++; $display("FAIL z_main_hyst got=%0b exp=0", ck_disable); end
        dmp_idle = 1'b1;
        tick();
        checks++; if (z_ck_dmp_gated !== 1'b1) begin failures++; $display("FAIL z_dmp_gate got=%0b exp=1", z_ck_dmp_gated); end
        checks++; if (z_gated_cycles !== 8'd1) begin failures++; $display("FAIL z_cnt got=%0d exp=1", z_gated_cycles); end
        halt_r = 1'b0;
        tick();
        checks++; if (z_ck_disable !== 1'b0) begin failures++; $display("FAIL z_wake got=%0b exp=0", z_ck_disable); end
        dmp_idle = 1'b0;
        tick();
        checks++; if (z_ck_dmp_gated !== 1'b0) begin failures++; $display("FAIL z_dmp_wake got=%0b exp=0", z_ck_dmp_gated); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        clear_inputs();
        test_reset();
        test_gate_latency();
        test_reset_mid_gated();
        test_wake_priority();
        test_dmp();
        test_test_mode();
        test_saturation();
        test_zero_hyst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
